fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo write port among NUM_REQ requesters. Each requester uses a valid/ready handshake. The block drives the fifo's write enable and write data, and throttles on the fifo full flag. Packet mode (req_last_i) holds the grant for one requester until its last beat is written, so multi-beat packets are never interleaved in the fifo.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, width of each requester data word and of the fifo write data
IDW, derived, clog2(NUM_REQ), minimum 1; width of the requester index

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester valid
req_last_i  input  NUM_REQ  per-requester last beat of packet (1 = single-beat)
req_data_i  input  NUM_REQ*DATA_WIDTH  requester data, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  output  NUM_REQ  per-requester ready, one-hot or zero
fifo_full_i  input  1  full flag from the fifo
fifo_wr_en_o  output  1  write enable to the fifo
fifo_wr_data_o  output  DATA_WIDTH  write data to the fifo
grant_id_o  output  IDW  index of the requester whose beat is written this cycle; 0 when fifo_wr_en_o=0
locked_o  output  1  1 while a multi-beat packet holds the grant

Behaviour:
- Zero latency: grant, ready and write are combinational in the same cycle. A beat transfers when req_valid_i[k] & req_ready_o[k]; in that cycle fifo_wr_en_o=1 and fifo_wr_data_o=req_data_i slice k.
- fifo_wr_en_o is never asserted while fifo_full_i=1. All req_ready_o=0 while full. State and priority pointer do not change while full.
- State registers: state {IDLE, LOCKED}, last_grant[IDW], owner[IDW].
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), owner=0, locked_o=0.
- While rst_n=0, all outputs are forced to 0.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, scanning cyclically from last_grant+1 (wraps NUM_REQ-1 -> 0).
  - If no valid, or fifo_full_i=1: no ready, no write, no state change.
  - On a transfer: last_grant<=winner.
  - If req_last_i[winner]=0: state<=LOCKED and owner<=winner.
  - If req_last_i[winner]=1: stay in IDLE.
- LOCKED:
  - Only the owner is considered: req_ready_o[owner]=!fifo_full_i; all other readys are 0 even if they are valid.
  - If the owner drops valid, the cycle is a bubble (no write) and the grant stays locked.
  - A transfer with req_last_i[owner]=1 sets state<=IDLE, so the next arbitration starts from owner+1.
  - last_grant is not updated during the locked beats; it was already set to owner on the first beat.
- locked_o = (state==LOCKED), registered.
- Requester protocol (not checked by the block): once valid is asserted, data and last are held stable until accepted. No hold or retraction handling is provided.
- Asynchronous reset mid-packet returns the block to IDLE immediately. Beats already written remain in the fifo; there is no cleanup or marker.
- The fifo full flag updates one cycle after a write. The block relies on the fifo only being written when full is low, which is exact because the fifo full flag is derived from registered pointers.

Test Plan:
- Reset: rst_n=0 with all valids high -> req_ready_o=0, fifo_wr_en_o=0, grant_id_o=0. After release, with all valids=1 and last=1 -> grants 0,1,2,3,0 on consecutive cycles.
- Fairness with a gap: valid=4'b1010, last=1 -> grants alternate 1,3,1,3. Then raise valid[0] -> sequence continues 0 after 3, giving 1,3,0,1,3,0.
- Packet lock: requester 2 sends 3 beats (last on the 3rd) while requesters 0 and 1 are valid -> writes are 2,2,2, then 0. locked_o=1 for the cycles after beats 1 and 2. A valid gap from requester 2 mid-packet produces a bubble, with no grant to 0 or 1.
- Full throttle: fifo_full_i=1 for 3 cycles with all valid -> no write and no ready. After fifo_full_i=0 the grant resumes at the next requester in order (no skipped requester).
- Integration with the fifo (DEPTH_WIDTH=2, no reads): 4 requesters send data 8'hA0..A3 -> exactly 4 writes, then full. Draining 4 reads returns A0,A1,A2,A3.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 3-beat packet from requester 1 -> locked_o goes to 0 immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side valid/ready bus plus fifo write-port signals for fifo_wr_arbiter.
// The arbiter uses the slave modport; requesters and the fifo sit on the master side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          fifo_full_i;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_wr_data_o;

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_wr_en_o, fifo_wr_data_o
  );

  modport master (
    output req_valid_i, req_last_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_wr_en_o, fifo_wr_data_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Zero-latency round-robin arbiter sharing one fifo write port among NUM_REQ
// requesters; multi-beat packets hold the grant until their last beat.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_wr_arbiter_if.slave     bus,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 locked_o
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t                r_state;
  logic [IDW-1:0]        r_last_grant;
  logic [IDW-1:0]        r_owner;

  state_t                w_next_state;
  logic [IDW-1:0]        w_next_last;
  logic [IDW-1:0]        w_next_owner;
  logic [IDW-1:0]        w_winner;
  logic                  w_any;
  logic [IDW-1:0]        w_sel;
  logic                  w_xfer;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_data[k] = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Cyclic scan starting just after the last granted requester.
  always_comb begin
    logic [IDW-1:0] idx;
    w_any    = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((32'(r_last_grant) + i) % NUM_REQ);
      if (!w_any && bus.req_valid_i[idx]) begin
        w_any    = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last_grant;
    w_next_owner = r_owner;
    w_sel        = r_owner;
    w_ready      = '0;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel = w_winner;
        if (w_any && !bus.fifo_full_i) begin
          w_ready[w_winner] = 1'b1;
          w_xfer            = 1'b1;
          w_next_last       = w_winner;
          if (!bus.req_last_i[w_winner]) begin
            w_next_state = ST_LOCKED;
            w_next_owner = w_winner;
          end
        end
      end
      ST_LOCKED: begin
        w_sel            = r_owner;
        w_ready[r_owner] = !bus.fifo_full_i;
        if (bus.req_valid_i[r_owner] && !bus.fifo_full_i) begin
          w_xfer = 1'b1;
          if (bus.req_last_i[r_owner]) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_owner      <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last;
      r_owner      <= w_next_owner;
    end
  end

  // Outputs are gated by rst_n so they read zero throughout reset.
  assign bus.req_ready_o    = rst_n ? w_ready : '0;
  assign bus.fifo_wr_en_o   = rst_n & w_xfer;
  assign bus.fifo_wr_data_o = (rst_n && w_xfer) ? w_data[w_sel] : '0;
  assign grant_id_o         = (rst_n && w_xfer) ? w_sel : '0;
  assign locked_o           = rst_n && (r_state == ST_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, corner-case
// sequences, a behavioural fifo, and randomized traffic against a reference model.
module tb_fifo_wr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [IDW-1:0] grant_id;
  logic           locked;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_id_o (grant_id),
    .locked_o   (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]     valid;
    logic [3:0]     last;
    logic           full;
    logic           en;
    logic [IDW-1:0] grant;
    logic [3:0]     ready;
    logic           lk;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [3:0] v, input logic [3:0] l, input logic f,
                         input logic e, input int g, input logic [3:0] r, input logic lk);
    vec_t x;
    x.valid = v; x.last = l; x.full = f; x.en = e;
    x.grant = IDW'(g); x.ready = r; x.lk = lk;
    tbl.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] fifo_q[$];

  logic [3:0]    sv, sl;
  logic [DW-1:0] sd [N];
  int            m_next, m_owner;
  bit            m_locked;

  initial begin
    int writes;
    logic [DW-1:0] popped;
    bit exp_en;
    int exp_g;
    logic [3:0] exp_ready;

    // Reset with every requester valid
    rst_n           = 1'b0;
    bus.req_valid_i = 4'hF;
    bus.req_last_i  = 4'hF;
    bus.req_data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.fifo_full_i = 1'b0;
    #3;
    check("rst_ready", bus.req_ready_o, 4'h0);
    check("rst_wr_en", bus.fifo_wr_en_o, 1'b0);
    check("rst_grant", grant_id, 0);
    check("rst_locked", locked, 1'b0);
    check("rst_data", bus.fifo_wr_data_o, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // valid, last, full | en, grant, ready, locked
    add_vec(4'hF, 4'hF, 0, 1, 0, 4'b0001, 0);
    add_vec(4'hF, 4'hF, 0, 1, 1, 4'b0010, 0);
    add_vec(4'hF, 4'hF, 0, 1, 2, 4'b0100, 0);
    add_vec(4'hF, 4'hF, 0, 1, 3, 4'b1000, 0);
    add_vec(4'hF, 4'hF, 0, 1, 0, 4'b0001, 0);
    add_vec(4'hA, 4'hF, 0, 1, 1, 4'b0010, 0);
    add_vec(4'hA, 4'hF, 0, 1, 3, 4'b1000, 0);
    add_vec(4'hA, 4'hF, 0, 1, 1, 4'b0010, 0);
    add_vec(4'hA, 4'hF, 0, 1, 3, 4'b1000, 0);
    add_vec(4'hB, 4'hF, 0, 1, 0, 4'b0001, 0);
    add_vec(4'hB, 4'hF, 0, 1, 1, 4'b0010, 0);
    add_vec(4'hB, 4'hF, 0, 1, 3, 4'b1000, 0);
    add_vec(4'hB, 4'hF, 0, 1, 0, 4'b0001, 0);
    add_vec(4'hF, 4'hF, 1, 0, 0, 4'b0000, 0);
    add_vec(4'hF, 4'hF, 1, 0, 0, 4'b0000, 0);
    add_vec(4'hF, 4'hF, 1, 0, 0, 4'b0000, 0);
    add_vec(4'hF, 4'hF, 0, 1, 1, 4'b0010, 0);
    add_vec(4'h7, 4'h0, 0, 1, 2, 4'b0100, 0);
    add_vec(4'h7, 4'h0, 0, 1, 2, 4'b0100, 1);
    add_vec(4'h3, 4'h0, 0, 0, 0, 4'b0100, 1);
    add_vec(4'h7, 4'h4, 0, 1, 2, 4'b0100, 1);
    add_vec(4'h3, 4'hF, 0, 1, 0, 4'b0001, 0);

    foreach (tbl[i]) begin
      bus.req_valid_i = tbl[i].valid;
      bus.req_last_i  = tbl[i].last;
      bus.fifo_full_i = tbl[i].full;
      #3;
      check($sformatf("vec%0d_wr_en", i), bus.fifo_wr_en_o, tbl[i].en);
      check($sformatf("vec%0d_grant", i), grant_id, tbl[i].grant);
      check($sformatf("vec%0d_ready", i), bus.req_ready_o, tbl[i].ready);
      check($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
      check($sformatf("vec%0d_data", i), bus.fifo_wr_data_o,
            tbl[i].en ? 8'h10 + 8'(tbl[i].grant) : 8'h00);
      @(posedge clk); #1;
    end

    // Integration with a depth-4 fifo whose full flag is registered
    do_reset();
    bus.fifo_full_i = 1'b0;
    bus.req_valid_i = 4'hF;
    bus.req_last_i  = 4'hF;
    bus.req_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    writes = 0;
    for (int c = 0; c < 8; c++) begin
      #3;
      exp_en = bus.fifo_wr_en_o;
      exp_g  = int'(grant_id);
      popped = bus.fifo_wr_data_o;
      @(posedge clk);
      if (exp_en) begin
        fifo_q.push_back(popped);
        writes++;
      end
      #1;
      if (exp_en) bus.req_valid_i[exp_g] = 1'b0;
      bus.fifo_full_i = (fifo_q.size() >= 4);
    end
    check("fifo_writes", writes, 4);
    check("fifo_full", bus.fifo_full_i, 1'b1);
    for (int i = 0; i < 4; i++) begin
      popped = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hXX;
      check($sformatf("fifo_pop%0d", i), popped, 8'hA0 + 8'(i));
    end

    // Reset in the middle of a 3-beat packet from requester 1
    do_reset();
    bus.fifo_full_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    bus.req_last_i  = 4'b0000;
    #3;
    check("pkt_beat1_en", bus.fifo_wr_en_o, 1'b1);
    check("pkt_beat1_grant", grant_id, 1);
    @(posedge clk); #1;
    check("pkt_locked", locked, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_locked", locked, 1'b0);
    check("midrst_wr_en", bus.fifo_wr_en_o, 1'b0);
    check("midrst_ready", bus.req_ready_o, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid_i = 4'b0011;
    bus.req_last_i  = 4'b1111;
    #3;
    check("postrst_grant", grant_id, 0);
    check("postrst_en", bus.fifo_wr_en_o, 1'b1);
    @(posedge clk); #1;

    // Randomized traffic against a reference model
    do_reset();
    m_next = 0; m_owner = 0; m_locked = 0;
    for (int k = 0; k < N; k++) begin
      sv[k] = 1'($urandom_range(0, 1));
      sl[k] = 1'($urandom_range(0, 1));
      sd[k] = 8'($urandom);
    end
    for (int c = 0; c < 400; c++) begin
      bus.req_valid_i = sv;
      bus.req_last_i  = sl;
      bus.req_data_i  = {sd[3], sd[2], sd[1], sd[0]};
      bus.fifo_full_i = ($urandom_range(0, 3) == 0);
      exp_en = 0; exp_g = 0; exp_ready = '0;
      if (!bus.fifo_full_i) begin
        if (m_locked) begin
          exp_ready[m_owner] = 1'b1;
          if (sv[m_owner]) begin exp_en = 1; exp_g = m_owner; end
        end else begin
          for (int j = 0; j < N; j++) begin
            if (!exp_en && sv[(m_next + j) % N]) begin
              exp_en = 1;
              exp_g  = (m_next + j) % N;
            end
          end
          if (exp_en) exp_ready[exp_g] = 1'b1;
        end
      end
      #3;
      check("rnd_wr_en", bus.fifo_wr_en_o, exp_en);
      check("rnd_grant", grant_id, exp_g);
      check("rnd_ready", bus.req_ready_o, exp_ready);
      check("rnd_data", bus.fifo_wr_data_o, exp_en ? sd[exp_g] : 8'h00);
      check("rnd_locked", locked, m_locked);
      @(posedge clk); #1;
      if (exp_en) begin
        if (!m_locked) begin
          m_next = (exp_g + 1) % N;
          if (!sl[exp_g]) begin m_locked = 1; m_owner = exp_g; end
        end else if (sl[exp_g]) begin
          m_locked = 0;
        end
        sv[exp_g] = 1'($urandom_range(0, 1));
        sl[exp_g] = 1'($urandom_range(0, 1));
        sd[exp_g] = 8'($urandom);
      end
      for (int k = 0; k < N; k++) begin
        if (!sv[k] && $urandom_range(0, 2) == 0) begin
          sv[k] = 1'b1;
          sl[k] = 1'($urandom_range(0, 1));
          sd[k] = 8'($urandom);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
